// File: rtl/fetch_imem_if_pkg.sv
// Shared constants, payload types and helpers for the fetch/instruction-memory block.
//   PC_WIDTH / INSTR_WIDTH : address and instruction widths
//   RESET_PC_DEF           : default first fetch address after reset
//   NOP_INSTR/NOP_PC/NOP_NPC : values driven on the fetch outputs when no entry is ready
//   fetch_meta_t           : {pc, npc} recorded when a request is issued
package fetch_imem_if_pkg;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0]    RESET_PC_DEF = 32'h8000_0000;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [PC_WIDTH-1:0]    NOP_PC       = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0]    NOP_NPC      = 32'h0000_0000;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] npc;
    } fetch_meta_t;

    // Instructions are word aligned; the two low address bits are always cleared.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] a);
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_imem_if_if.sv
// Instruction-memory request/response bus.
//   req/addr : request valid and word address (fetch side drives)
//   gnt      : request accepted this cycle
//   rvalid/rdata : in-order response
interface fetch_imem_if_if;
    import fetch_imem_if_pkg::*;

    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic                   gnt;
    logic                   rvalid;
    logic [INSTR_WIDTH-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_entry_q.sv
// DEPTH-entry circular queue of fetch entries with three pointers:
// alloc (tail, written on issue), fill (next entry awaiting its response) and pop (head).
// Entries between pop and fill are filled; between fill and alloc are still waiting.
//   clk_i, rst_n    : clock, synchronous active-low reset
//   flush_i         : drop every entry (takes priority over other requests)
//   alloc_i/alloc_meta_i : allocate tail entry with {pc, npc}
//   fill_i/fill_instr_i  : write instruction into the oldest unfilled entry
//   pop_i           : remove the head entry if it is filled
//   count_o         : allocated entries, filled or not
//   head_filled_o/head_meta_o/head_instr_o : head entry view
module fetch_entry_q
    import fetch_imem_if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          alloc_i,
    input  fetch_meta_t                   alloc_meta_i,
    input  logic                          fill_i,
    input  logic [INSTR_WIDTH-1:0]        fill_instr_i,
    input  logic                          pop_i,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          head_filled_o,
    output fetch_meta_t                   head_meta_o,
    output logic [INSTR_WIDTH-1:0]        head_instr_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0]          alloc_ptr_q;
    logic [PW-1:0]          fill_ptr_q;
    logic [PW-1:0]          pop_ptr_q;
    fetch_meta_t            meta_q  [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];

    logic alloc_ok;
    logic fill_ok;
    logic pop_ok;

    // Guards keep the pointers ordered even if a caller misbehaves.
    assign count_o       = alloc_ptr_q - pop_ptr_q;
    assign head_filled_o = (fill_ptr_q != pop_ptr_q);
    assign alloc_ok      = alloc_i & (count_o != PW'(DEPTH));
    assign fill_ok       = fill_i & (fill_ptr_q != alloc_ptr_q);
    assign pop_ok        = pop_i & head_filled_o;

    assign head_meta_o  = meta_q[pop_ptr_q[IW-1:0]];
    assign head_instr_o = instr_q[pop_ptr_q[IW-1:0]];

    // Pointer state.
    always_ff @(posedge clk_i) begin
        if (!rst_n || flush_i) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            pop_ptr_q   <= '0;
        end else begin
            if (alloc_ok) alloc_ptr_q <= alloc_ptr_q + PW'(1);
            if (fill_ok)  fill_ptr_q  <= fill_ptr_q + PW'(1);
            if (pop_ok)   pop_ptr_q   <= pop_ptr_q + PW'(1);
        end
    end

    // Entry storage; contents are qualified by the pointers so they need no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_ok && !flush_i) meta_q[alloc_ptr_q[IW-1:0]] <= alloc_meta_i;
        if (fill_ok && !flush_i)  instr_q[fill_ptr_q[IW-1:0]] <= fill_instr_i;
    end

endmodule

// File: rtl/fetch_imem_if.sv
// Fetch-side producer: generates the PC, issues in-order instruction-memory requests,
// tracks variable-latency responses and presents completed {instr, PC, nPC} entries.
//   clk_i, rst_n          : clock, synchronous active-low reset
//   imem                  : instruction-memory bus (master side)
//   bp_taken_i/bp_target_i: combinational prediction for the instruction at imem.addr
//   redirect_i/redirect_pc_i : flush and restart from a later stage
//   decode_allow_in_i     : downstream can take the head entry
//   fetch_ready_o, instr_o, F_PC_o, F_nPC_o : head entry (nop values when not ready)
module fetch_imem_if
    import fetch_imem_if_pkg::*;
#(
    parameter int unsigned         DEPTH    = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    fetch_imem_if_if.master        imem,
    input  logic                   bp_taken_i,
    input  logic [PC_WIDTH-1:0]    bp_target_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    input  logic                   decode_allow_in_i,
    output logic                   fetch_ready_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    F_PC_o,
    output logic [PC_WIDTH-1:0]    F_nPC_o
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = PW + 1;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PW-1:0]       kill_cnt_q;
    logic [PW-1:0]       pend_cnt_q;
    logic                active_q;

    logic [PW-1:0]       q_count;
    logic                head_filled;
    fetch_meta_t         head_meta;
    logic [INSTR_WIDTH-1:0] head_instr;

    logic [PC_WIDTH-1:0] npc_c;
    logic                credit_c;
    logic                issue_c;
    logic                rsp_kill_c;
    logic                rsp_fill_c;
    logic                pop_c;
    logic [CW-1:0]       kill_sum_c;
    logic [CW-1:0]       kill_redirect_c;
    logic                rsp_spurious_c;

    // Predicted next PC for the request currently on the bus.
    assign npc_c = bp_taken_i ? align_pc(bp_target_i) : align_pc(pc_q + PC_WIDTH'(4));

    // Entries still owed a response plus responses still to be discarded must fit the queue.
    assign credit_c = (CW'(q_count) + CW'(kill_cnt_q)) < CW'(DEPTH);
    assign imem.req  = rst_n & active_q & ~redirect_i & credit_c;
    assign imem.addr = pc_q;
    assign issue_c   = imem.req & imem.gnt;

    // Stale responses are discarded first; the rest fill entries in order.
    assign rsp_kill_c     = imem.rvalid & (kill_cnt_q != '0);
    assign rsp_fill_c     = imem.rvalid & (kill_cnt_q == '0) & (pend_cnt_q != '0);
    assign rsp_spurious_c = imem.rvalid & (kill_cnt_q == '0) & (pend_cnt_q == '0);

    // Every outstanding request becomes a kill on redirect, except one answered this cycle.
    assign kill_sum_c      = CW'(kill_cnt_q) + CW'(pend_cnt_q);
    assign kill_redirect_c = kill_sum_c - CW'(imem.rvalid && (kill_sum_c != '0));

    assign fetch_ready_o = rst_n & head_filled;
    assign pop_c         = fetch_ready_o & decode_allow_in_i & ~redirect_i;

    assign instr_o = fetch_ready_o ? head_instr    : NOP_INSTR;
    assign F_PC_o  = fetch_ready_o ? head_meta.pc  : NOP_PC;
    assign F_nPC_o = fetch_ready_o ? head_meta.npc : NOP_NPC;

    // PC, response bookkeeping and the post-reset request gate.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            kill_cnt_q <= '0;
            pend_cnt_q <= '0;
            active_q   <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (redirect_i) begin
                pc_q       <= align_pc(redirect_pc_i);
                kill_cnt_q <= PW'(kill_redirect_c);
                pend_cnt_q <= '0;
            end else begin
                if (issue_c) pc_q <= npc_c;
                pend_cnt_q <= pend_cnt_q + PW'(issue_c) - PW'(rsp_fill_c);
                kill_cnt_q <= kill_cnt_q - PW'(rsp_kill_c);
            end
        end
    end

    fetch_entry_q #(
        .DEPTH (DEPTH)
    ) u_entry_q (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .flush_i      (redirect_i),
        .alloc_i      (issue_c),
        .alloc_meta_i ('{pc: pc_q, npc: npc_c}),
        .fill_i       (rsp_fill_c & ~redirect_i),
        .fill_instr_i (imem.rdata),
        .pop_i        (pop_c),
        .count_o      (q_count),
        .head_filled_o(head_filled),
        .head_meta_o  (head_meta),
        .head_instr_o (head_instr)
    );

    // A response with nothing outstanding means the memory broke the protocol.
    a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_n) !rsp_spurious_c);

endmodule
